// File: rtl/universal_register.sv
// universal_register: clear/load/inc/dec/multi-cycle shift register; define UNIVERSAL_REGISTER_SAT_EN for saturating inc/dec
module universal_register #(
  parameter int DATA_WIDTH = 16,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cl,
  input  logic                   ld,
  input  logic [DATA_WIDTH-1:0]  in,
  input  logic                   inc,
  input  logic                   dec,
  input  logic                   sr,
  input  logic                   ir,
  input  logic                   sl,
  input  logic                   il,
  input  logic                   rot,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  out,
  output logic                   carry,
  output logic                   zero,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] out_n, step_out;
  logic [SHAMT_WIDTH-1:0] cnt, cnt_n, n;
  logic carry_n, done_n, left, left_n, rot_q, rot_n, fill_q, fill_n;
  logic s_left, s_rot, s_fill, step_carry, all_ones, in_shift;
  assign in_shift = state == SHIFT;
  assign busy = in_shift;
  assign zero = out == '0;
  assign all_ones = &out;
  assign n = shamt > SHAMT_WIDTH'(DATA_WIDTH) ? SHAMT_WIDTH'(DATA_WIDTH) : shamt;
  assign s_left = in_shift ? left : ~sr;
  assign s_rot = in_shift ? rot_q : rot;
  assign s_fill = in_shift ? fill_q : (sr ? ir : il);
  assign step_out = s_left ? {out[DATA_WIDTH-2:0], s_rot ? out[DATA_WIDTH-1] : s_fill}
                           : {s_rot ? out[0] : s_fill, out[DATA_WIDTH-1:1]};
  assign step_carry = s_left ? out[DATA_WIDTH-1] : out[0];
  always_comb begin
    state_n = state;
    out_n = out;
    carry_n = carry;
    cnt_n = cnt;
    left_n = left;
    rot_n = rot_q;
    fill_n = fill_q;
    done_n = 1'b0;
    if (in_shift) begin
      if (cl) begin
        out_n = '0;
        carry_n = 1'b0;
        cnt_n = '0;
        state_n = IDLE;
      end else begin
        out_n = step_out;
        carry_n = step_carry;
        cnt_n = cnt - SHAMT_WIDTH'(1);
        if (cnt == SHAMT_WIDTH'(1)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
    end else if (cl) begin
      out_n = '0;
      carry_n = 1'b0;
    end else if (ld) begin
      out_n = in;
      carry_n = 1'b0;
    end else if (inc) begin
`ifdef UNIVERSAL_REGISTER_SAT_EN
      out_n = all_ones ? out : out + DATA_WIDTH'(1);
`else
      out_n = out + DATA_WIDTH'(1);
`endif
      carry_n = all_ones;
    end else if (dec) begin
`ifdef UNIVERSAL_REGISTER_SAT_EN
      out_n = zero ? out : out - DATA_WIDTH'(1);
`else
      out_n = out - DATA_WIDTH'(1);
`endif
      carry_n = zero;
    end else if ((sr || sl) && n != '0) begin
      out_n = step_out;
      carry_n = step_carry;
      left_n = s_left;
      rot_n = s_rot;
      fill_n = s_fill;
      cnt_n = n - SHAMT_WIDTH'(1);
      if (n == SHAMT_WIDTH'(1)) done_n = 1'b1;
      else state_n = SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out <= '0;
      carry <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      left <= 1'b0;
      rot_q <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      state <= state_n;
      out <= out_n;
      carry <= carry_n;
      cnt <= cnt_n;
      done <= done_n;
      left <= left_n;
      rot_q <= rot_n;
      fill_q <= fill_n;
    end
  end
endmodule
